// File: rtl/rs_dec_inv_arb.sv
// rs_dec_inv_arb: round-robin arbiter/sequencer sharing one multi-cycle
// GF(256) inverter between N_REQ requesters (C1/C2 Euclid engines).
// Flow: IDLE -> START (inverter start pulse) -> WAIT (done or timeout)
// -> RESP (one-cycle ack to the granted requester) -> IDLE.
// Optional feature macro: RS_INV_ARB_ZERO_BYPASS_EN -- when defined, a zero
// operand skips the inverter and is answered directly with o_zero=1.
module rs_dec_inv_arb #(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic               i_clk,
  input  logic               i_resb,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_x,
  output logic [N_REQ-1:0]   o_ack,
  output logic [7:0]         o_y,
  output logic               o_err,
  output logic               o_zero,
  output logic               o_inv_start,
  output logic [7:0]         o_inv_x,
  input  logic [7:0]         i_inv_y,
  input  logic               i_inv_done,
  output logic               o_busy
);

  localparam int GW = (N_REQ > 2) ? 2 : 1;
  localparam logic [GW:0]      NR_W   = (GW+1)'(N_REQ);
  localparam logic [GW-1:0]    PTR_RST = GW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
  localparam logic [7:0]       TMO_W  = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] r_gnt;
  logic [GW-1:0] r_ptr;
  logic [GW-1:0] gnt_sel;
  logic          gnt_any;
  logic [GW:0]   rr_sum;
  logic [GW-1:0] rr_idx;
  logic [7:0]    x_sel;
  logic [7:0]    cnt;
  logic          r_err;
  logic          r_zero;
  logic          tmo_hit;
  logic          zero_hit;
  logic          ack_hit;

  // Round-robin search: first requester at or after r_ptr+1 (wrapping).
  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = '0;
    rr_sum  = '0;
    rr_idx  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      rr_sum = {1'b0, r_ptr} + (GW+1)'(i);
      if (rr_sum >= NR_W) rr_sum = rr_sum - NR_W;
      rr_idx = rr_sum[GW-1:0];
      if (!gnt_any && i_req[rr_idx]) begin
        gnt_any = 1'b1;
        gnt_sel = rr_idx;
      end
    end
  end

  // Operand mux for the requester being granted this cycle.
  always_comb begin
    x_sel = 8'h00;
    for (int j = 0; j < N_REQ; j++) begin
      if (gnt_sel == GW'(j)) x_sel = i_x[8*j +: 8];
    end
  end

`ifdef RS_INV_ARB_ZERO_BYPASS_EN
  assign zero_hit = (x_sel == 8'h00);
`else
  assign zero_hit = 1'b0;
`endif

  assign tmo_hit = (cnt == TMO_W);

  // Next-state logic; done is only honoured in WAIT so stale pulses are harmless.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = zero_hit ? RESP : START;
      START:   state_nxt = WAIT;
      WAIT:    if (i_inv_done || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) state <= IDLE;
    else         state <= state_nxt;
  end

  // Grant, operand, timeout counter, result and status flags.
  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      r_gnt   <= '0;
      r_ptr   <= PTR_RST;
      o_inv_x <= 8'h00;
      o_y     <= 8'h00;
      cnt     <= 8'h00;
      r_err   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            r_gnt   <= gnt_sel;
            o_inv_x <= x_sel;
            r_err   <= 1'b0;
            r_zero  <= zero_hit;
            if (zero_hit) o_y <= 8'h00;
          end
        end
        START: cnt <= 8'h00;
        WAIT: begin
          if (i_inv_done) begin
            o_y <= i_inv_y;
          end else if (tmo_hit) begin
            o_y   <= 8'h00;
            r_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: r_ptr <= r_gnt;
        default: ;
      endcase
    end
  end

  // A requester that dropped its request before RESP gets no ack.
  assign ack_hit     = (state == RESP) && i_req[r_gnt];
  assign o_ack       = ack_hit ? (ONE_HOT0 << r_gnt) : '0;
  assign o_err       = ack_hit & r_err;
  assign o_zero      = ack_hit & r_zero;
  assign o_inv_start = (state == START);
  assign o_busy      = (state != IDLE);

endmodule

// File: tb/tb_rs_dec_inv_arb.sv
// Testbench for rs_dec_inv_arb: directed scenarios plus a randomized run,
// checked against a round-robin / GF(256) reference model held in the bench.
module tb_rs_dec_inv_arb;

  localparam int NR  = 2;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          resb;
  logic [NR-1:0] req;
  logic [8*NR-1:0] xin;
  logic [NR-1:0] ack;
  logic [7:0]    y;
  logic          err;
  logic          zero;
  logic          start;
  logic [7:0]    inv_x;
  logic [7:0]    inv_y;
  logic          inv_done;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int ptr;
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  rs_dec_inv_arb #(.N_REQ(NR), .TIMEOUT_CYC(TMO)) dut (
    .i_clk       (clk),
    .i_resb      (resb),
    .i_req       (req),
    .i_x         (xin),
    .o_ack       (ack),
    .o_y         (y),
    .o_err       (err),
    .o_zero      (zero),
    .o_inv_start (start),
    .o_inv_x     (inv_x),
    .i_inv_y     (inv_y),
    .i_inv_done  (inv_done),
    .o_busy      (busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
    end
    return p;
  endfunction

  function automatic int pick(input logic [NR-1:0] r, input int p);
    for (int i = 1; i <= NR; i++) begin
      if (r[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   32'(ack),   0);
    chk({tag, "_y"},     32'(y),     0);
    chk({tag, "_err"},   32'(err),   0);
    chk({tag, "_zero"},  32'(zero),  0);
    chk({tag, "_start"}, 32'(start), 0);
    chk({tag, "_invx"},  32'(inv_x), 0);
    chk({tag, "_busy"},  32'(busy),  0);
  endtask

  // One operation from an IDLE cycle. dly = WAIT cycles before done,
  // tmo = never send done, drop = granted requester withdraws during WAIT.
  task automatic op(input int dly, input bit tmo, input bit drop);
    int k;
    logic [7:0] x;
    bit zb;
    k = pick(req, ptr);
    if (k < 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL op_noreq: observed no request expected one");
      return;
    end
    x  = xin[8*k +: 8];
    zb = 1'b0;
`ifdef RS_INV_ARB_ZERO_BYPASS_EN
    zb = (x == 8'h00);
`endif
    tick();
    if (!zb) begin
      chk("start_pulse", 32'(start), 1);
      chk("inv_x",       32'(inv_x), 32'(x));
      chk("busy_start",  32'(busy),  1);
      chk("ack_start",   32'(ack),   0);
      tick();
      if (tmo) begin
        for (int c = 0; c <= TMO; c++) begin
          chk("tmo_wait_ack",   32'(ack),   0);
          chk("tmo_wait_start", 32'(start), 0);
          tick();
        end
      end else begin
        for (int c = 0; c < dly; c++) begin
          if (drop && c == 0) req[k] = 1'b0;
          chk("wait_ack",   32'(ack),   0);
          chk("wait_start", 32'(start), 0);
          tick();
        end
        if (drop && dly == 0) req[k] = 1'b0;
        inv_done = 1'b1;
        inv_y    = inv_tab[x];
        tick();
        inv_done = 1'b0;
        inv_y    = 8'($urandom_range(0, 255));
      end
    end else begin
      chk("zb_no_start", 32'(start), 0);
    end
    chk("ack", 32'(ack), drop ? 32'd0 : (32'd1 << k));
    chk("busy_resp", 32'(busy), 1);
    if (!drop) begin
      chk("y",    32'(y),    (tmo || zb) ? 32'd0 : 32'(inv_tab[x]));
      chk("err",  32'(err),  32'(tmo));
      chk("zero", 32'(zero), 32'(zb));
    end
    ptr = k;
    tick();
    chk("busy_idle", 32'(busy), 0);
    chk("ack_idle",  32'(ack),  0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int kk;
    int b;
    bit drop;
    bit tmo;
    resb     = 1'b0;
    req      = '0;
    xin      = '0;
    inv_done = 1'b0;
    inv_y    = 8'h00;
    ptr      = NR - 1;
    for (int x = 0; x < 256; x++) begin
      inv_tab[x] = 8'h00;
      for (int v = 1; v < 256; v++) begin
        if (gmul(8'(x), 8'(v)) == 8'h01) inv_tab[x] = 8'(v);
      end
    end

    // Reset state.
    repeat (2) tick();
    chk_all_zero("reset");
    resb = 1'b1;
    tick();
    chk_all_zero("post_reset");

    // Single request, inverse of 0x02.
    req = 2'b01;
    xin[7:0] = 8'h02;
    op(3, 0, 0);
    chk("single_y_8e", 32'(y), 32'h8E);
    req = '0;

    // Both requesters held high: grants alternate.
    xin = {8'h53, 8'h03};
    req = 2'b11;
    op(2, 0, 0);
    op(2, 0, 0);
    op(2, 0, 0);
    req = '0;

    // Timeout, then a normal operation.
    req = 2'b01;
    xin[7:0] = 8'h05;
    op(0, 1, 0);
    op(1, 0, 0);
    req = '0;

    // Requester 1 drops during WAIT; requester 0 served next.
    req = 2'b11;
    xin = {8'h9A, 8'h11};
    op(3, 0, 1);
    op(1, 0, 0);
    req = '0;

    // Reset during WAIT with a stale done after release.
    req = 2'b01;
    xin[7:0] = 8'h07;
    tick();
    tick();
    tick();
    resb = 1'b0;
    req  = '0;
    #1;
    chk_all_zero("rst_wait");
    tick();
    tick();
    resb = 1'b1;
    ptr  = NR - 1;
    tick();
    inv_done = 1'b1;
    inv_y    = 8'h55;
    tick();
    inv_done = 1'b0;
    chk_all_zero("stale_done");
    req = 2'b11;
    xin = {8'h21, 8'h42};
    op(2, 0, 0);
    req = '0;

    // Zero operand.
    req = 2'b01;
    xin[7:0] = 8'h00;
    op(2, 0, 0);
    req = '0;

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      if (req == '0) begin
        b = $urandom_range(0, NR - 1);
        req[b] = 1'b1;
        xin[8*b +: 8] = 8'($urandom_range(0, 255));
      end
      kk   = pick(req, ptr);
      tmo  = ($urandom_range(0, 9) == 0);
      drop = !tmo && ($urandom_range(0, 5) == 0) && (xin[8*kk +: 8] != 8'h00);
      op($urandom_range(0, 5), tmo, drop);
      if (!drop) begin
        if ($urandom_range(0, 1) == 1) xin[8*kk +: 8] = 8'($urandom_range(0, 255));
        else req[kk] = 1'b0;
      end
      for (int j = 0; j < NR; j++) begin
        if (j != kk && !req[j] && $urandom_range(0, 1) == 1) begin
          req[j] = 1'b1;
          xin[8*j +: 8] = 8'($urandom_range(0, 255));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_dec_inv_arb.md
# rs_dec_inv_arb

Round-robin arbiter and sequencer that shares one multi-cycle GF(256) inverter between several requesters in the CD decoder (default: the C1 RS(32,28) and C2 RS(28,24) Euclid engines). It accepts operand requests, launches the inverter, waits for its done, and returns the inverse to the granted requester with a one-cycle acknowledge. It sits between the Euclid engines and the single `gf256_inv` instance in the RS decode path.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters, 2..4.
- `TIMEOUT_CYC`, 15: maximum WAIT cycles before abort, 1..255.

Ports:
- `i_clk`  in  1  clock.
- `i_resb`  in  1  asynchronous active-low reset.
- `i_req`  in  N_REQ  per-requester request level; held high with the operand stable until its `o_ack` bit pulses.
- `i_x`  in  8*N_REQ  operands, requester k on bits [8k+7:8k].
- `o_ack`  out  N_REQ  one-hot, one-cycle result strobe.
- `o_y`  out  8  inverse result; valid while any `o_ack` bit is high.
- `o_err`  out  1  high with `o_ack` when the operation timed out; `o_y`=0 in that case.
- `o_zero`  out  1  high with `o_ack` when the operand was 0 (bypass only).
- `o_inv_start`  out  1  one-cycle start pulse to the inverter.
- `o_inv_x`  out  8  operand to the inverter, registered, stable from START to the end of WAIT.
- `i_inv_y`  in  8  inverter result.
- `i_inv_done`  in  1  inverter done; `i_inv_y` valid in the same cycle.
- `o_busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: if any `i_req` bit is high, grant the first requester at or after `r_ptr+1` (mod N_REQ). Register the grant index into `r_gnt` and its operand into `o_inv_x`. Go to START.
- START: `o_inv_start`=1. Clear the timeout counter. Go to WAIT.
- WAIT:
  - On `i_inv_done`=1: capture `i_inv_y` into `o_y` and go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYC: set `o_y`=0, set the error flag, go to RESP.
- RESP:
  - `o_ack[r_gnt]`=1 only if `i_req[r_gnt]` is still high. If the requester has dropped its request, the result is discarded silently.
  - Set `r_ptr`=`r_gnt` and go to IDLE.
- Arbitration:
  - The grant is fixed for the whole operation; new requests arriving mid-operation wait.
  - Ties resolve by round-robin. Reset value `r_ptr`=N_REQ-1, so requester 0 wins first.
- `i_inv_done` is ignored in IDLE, START and RESP. This covers late or stale done pulses, including those from before a reset.
- Reset, asynchronous and valid mid-operation:
  - State returns to IDLE.
  - All outputs go to 0: `o_ack`, `o_y`, `o_err`, `o_zero`, `o_inv_start`, `o_inv_x`, `o_busy`.
  - `r_ptr`=N_REQ-1 and the counter clears.
- Outputs `o_ack`, `o_err` and `o_zero` are decoded from state and registered flags. They are 0 outside RESP.

## Timing
- A request sampled at edge 0 (IDLE) is followed by:
  - START during cycle 1;
  - WAIT from cycle 2;
  - RESP in the cycle after the edge that sees `i_inv_done`.
- Minimum latency from the sampling edge to `o_ack`: 3 cycles plus the inverter's done delay measured from WAIT entry.
- The arbiter spends one IDLE cycle between consecutive operations. Maximum throughput is one operation per (4 + inverter latency) cycles.
- Timeout: `o_ack` with `o_err` arrives TIMEOUT_CYC+1 cycles after WAIT entry if done never comes.
- A requester may drop `i_req` in the cycle after its `o_ack`. If `i_req` is still high one cycle after `o_ack`, that is a new request.

## Configuration
- `RS_INV_ARB_ZERO_BYPASS_EN`
  - Defined: in IDLE, a granted operand of 0x00 goes directly to RESP with `o_y`=0 and `o_zero`=1. No inverter start is issued. Latency is 1 cycle from the sampling edge.
  - Undefined: zero operands pass through the inverter like any other value, and `o_zero` is tied to 0.

## Test plan
- Single request: `i_req`=01, x=0x02, inverter done 3 cycles after start → `o_ack`=01 with `o_y`=0x8E (inverse of 0x02 in the 0x11D field), exactly one `o_inv_start` pulse, `o_err`=0.
- Simultaneous `i_req`=11 held through repeated operations (x0=0x03, x1=0x53) → acks alternate 01, 10, 01.
- Timeout: TIMEOUT_CYC=15, `i_inv_done` tied to 0 → `o_ack` with `o_err`=1 and `o_y`=0, 16 cycles after WAIT entry. The next request then proceeds normally.
- Reset asserted in WAIT, with a stale `i_inv_done` arriving 1 cycle after release → all outputs stay 0 and no ack is generated. The next grant goes to requester 0.
- Requester 1 drops `i_req` during WAIT → no `o_ack`. A pending requester 0 is served in the following operation.
- x=0x00:
  - With `RS_INV_ARB_ZERO_BYPASS_EN`: ack one cycle after sampling, `o_zero`=1, no `o_inv_start`.
  - Without the macro: the operand goes through the inverter and `o_zero` stays 0.
